// File: rtl/reg_file_sb.sv
// Scoreboarded register file: combinational read ports with optional write bypass,
// plus a per-register busy bit set by reservations and cleared by writes.
`timescale 1ns/1ps

module reg_file_sb_rport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [NREGS-1:0][XLEN-1:0] regs_i,
  input  logic [NREGS-1:0]           busy_i,
  input  logic [AW-1:0]              raddr_i,
  input  logic                       byp_we_i,
  input  logic [AW-1:0]              waddr_i,
  input  logic [XLEN-1:0]            wdata_i,
  input  logic                       byp_rsv_i,
  input  logic [AW-1:0]              rsv_addr_i,
  output logic [XLEN-1:0]            rdata_o,
  output logic                       rbusy_o
);
  logic in_range;
  assign in_range = ({1'b0, raddr_i} < (AW+1)'(NREGS));

  always_comb begin
    rdata_o = '0;
    rbusy_o = 1'b0;
    if (in_range) begin
      rdata_o = regs_i[raddr_i];
      rbusy_o = busy_i[raddr_i];
    end
    // byp_we_i is already range/zero-reg/reset qualified, so forwarding is safe here
    if (BYPASS != 0 && byp_we_i && waddr_i == raddr_i) begin
      rdata_o = wdata_i;
      rbusy_o = byp_rsv_i && (rsv_addr_i == raddr_i);
    end
  end
endmodule

module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRPORTS  = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_we,
  input  logic [AW-1:0]           i_waddr,
  input  logic [XLEN-1:0]         i_wdata,
  input  logic                    i_rsv,
  input  logic [AW-1:0]           i_rsv_addr,
  input  logic [NRPORTS*AW-1:0]   i_raddr,
  output logic [NRPORTS*XLEN-1:0] o_rdata,
  output logic [NRPORTS-1:0]      o_rbusy,
  output logic [NREGS-1:0]        o_busy_vec
);
  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy_q, busy_d;
  logic                       wr_ok, rsv_ok;

  // Register 0 (when hardwired) and out-of-range targets never reach state
  assign wr_ok  = i_we  && ({1'b0, i_waddr}    < (AW+1)'(NREGS)) &&
                  !(ZERO_REG != 0 && i_waddr == '0);
  assign rsv_ok = i_rsv && ({1'b0, i_rsv_addr} < (AW+1)'(NREGS)) &&
                  !(ZERO_REG != 0 && i_rsv_addr == '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[i_waddr]    = 1'b0;
    if (rsv_ok) busy_d[i_rsv_addr] = 1'b1;  // new producer wins over the completing write
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[i_waddr] <= i_wdata;
      busy_q <= busy_d;
    end
  end

  assign o_busy_vec = busy_q;

  for (genvar k = 0; k < NRPORTS; k++) begin : g_rport
    reg_file_sb_rport #(
      .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .BYPASS(BYPASS)
    ) u_rport (
      .regs_i     (regs_q),
      .busy_i     (busy_q),
      .raddr_i    (i_raddr[k*AW +: AW]),
      .byp_we_i   (wr_ok && i_rst_n),
      .waddr_i    (i_waddr),
      .wdata_i    (i_wdata),
      .byp_rsv_i  (rsv_ok && i_rst_n),
      .rsv_addr_i (i_rsv_addr),
      .rdata_o    (o_rdata[k*XLEN +: XLEN]),
      .rbusy_o    (o_rbusy[k])
    );
  end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 The module SHALL have parameter NREGS, default 32, meaning the register count, with legal range 2..64; address width AW SHALL be ceil(log2(NREGS)).
REQ-003 The module SHALL have parameter NRPORTS, default 2, meaning the number of read ports, with legal range 1..4.
REQ-004 The module SHALL have parameter BYPASS, default 1, meaning that same-cycle write data is forwarded to the read ports when 1 and registered contents only are returned when 0.
REQ-005 The module SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1 and behaves as an ordinary register when 0.
REQ-006 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port i_clk SHALL be an input, 1 bit wide, the clock; all state is updated on its rising edge.
REQ-008 Port i_rst_n SHALL be an input, 1 bit wide, the asynchronous active-low reset.
REQ-009 Port i_we SHALL be an input, 1 bit wide, the write enable.
REQ-010 Port i_waddr SHALL be an input, AW bits wide, the write address.
REQ-011 Port i_wdata SHALL be an input, XLEN bits wide, the write data.
REQ-012 Port i_rsv SHALL be an input, 1 bit wide, a reservation strobe that marks a destination register busy.
REQ-013 Port i_rsv_addr SHALL be an input, AW bits wide, the register to reserve.
REQ-014 Port i_raddr SHALL be an input, NRPORTS*AW bits wide, the packed read addresses, with port k at bits [k*AW +: AW].
REQ-015 Port o_rdata SHALL be an output, NRPORTS*XLEN bits wide, the packed read data, with port k at bits [k*XLEN +: XLEN].
REQ-016 Port o_rbusy SHALL be an output, NRPORTS bits wide, the busy flag of each addressed register.
REQ-017 Port o_busy_vec SHALL be an output, NREGS bits wide, the registered busy bit of every register.

Function
REQ-018 Each read port SHALL be combinational: o_rdata and o_rbusy SHALL follow the current i_raddr with zero latency.
REQ-019 A write with i_we=1 SHALL update the addressed register at the rising edge of i_clk, and the new value SHALL be readable in the following cycle.
REQ-020 When BYPASS=1, i_we=1 and i_waddr equals port k's address, o_rdata for port k SHALL equal i_wdata in the same cycle and o_rbusy[k] SHALL be 0 unless i_rsv targets the same register that cycle.
REQ-021 When BYPASS=0, each read port SHALL return the pre-edge registered contents and busy bit.
REQ-022 When ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, reservations of address 0 SHALL be ignored, and busy bit 0 SHALL remain 0, including under bypass.
REQ-023 A write or reservation to an address >= NREGS SHALL be ignored, and a read of an address >= NREGS SHALL return data 0 with busy 0.
REQ-024 i_rsv=1 SHALL set the busy bit of i_rsv_addr at the rising edge of i_clk.
REQ-025 i_we=1 SHALL clear the busy bit of i_waddr at the rising edge of i_clk.
REQ-026 When i_rsv and i_we target the same register in the same cycle, the write data SHALL be stored and the busy bit SHALL end the cycle at 1 (the new producer wins).
REQ-027 When i_rsv and i_we target different registers in the same cycle, both updates SHALL take effect independently.
REQ-028 A reservation of an already-busy register SHALL leave it busy, and a write to a non-busy register SHALL be legal and leave it not busy.
REQ-029 Multiple read ports SHALL be able to address the same register concurrently and SHALL return identical data.

Reset
REQ-030 While i_rst_n=0, all registers SHALL be cleared to 0 and all busy bits to 0 asynchronously, independent of i_clk.
REQ-031 While i_rst_n=0, o_rdata SHALL read all zeros, o_rbusy SHALL be 0, and o_busy_vec SHALL be 0.
REQ-032 Writes and reservations presented during reset SHALL be discarded.
REQ-033 Reset asserted between a reservation and its write SHALL leave that register not busy and holding 0 after release.
REQ-034 The first write after reset release SHALL take effect on the first rising edge at which i_rst_n=1.

Verification
REQ-035 The bench SHALL write 0xDEADBEEF to x18 and 0xBABECAFE to x19, then read port 0 at x18 and port 1 at x19, and SHALL see 0xDEADBEEF and 0xBABECAFE.
REQ-036 The bench SHALL write 0xBBC0FFEE to x0 and 0xEFBEADDE to x1, then read x0 and x1, and SHALL see 0x00000000 and 0xEFBEADDE; with ZERO_REG=0 it SHALL see 0xBBC0FFEE and 0xEFBEADDE.
REQ-037 The bench SHALL apply a same-cycle write of 0x12345678 to x5 while reading x5, and SHALL see 0x12345678 in that cycle with BYPASS=1 and the old value with BYPASS=0.
REQ-038 The bench SHALL reserve x7, check o_busy_vec[7]=1 and o_rbusy=1 when reading x7, then write x7 with 0xA5A5A5A5 and check busy=0 and data=0xA5A5A5A5.
REQ-039 The bench SHALL apply a simultaneous reserve and write to x9 with data 0x00000042, and SHALL see data 0x42 with busy=1 in the next cycle.
REQ-040 The bench SHALL reserve x3, write x4 with 0xFFFFFFFF, pulse i_rst_n low mid-cycle, and SHALL see all data 0 and o_busy_vec=0 immediately, before any clock edge.
